// File: rtl/lif_update_if.sv
// Bundle between the convolution accumulator, the LIF membrane stage and its consumer.
// The master drives current beats and control; the slave reports spikes and sweep status.
interface lif_update_if #(
    parameter int DATA_WIDTH = 15,
    parameter int MEM_WIDTH  = 18,
    parameter int NEURONS    = 32
);
    localparam int IDX_W = $clog2(NEURONS);

    logic                          in_valid;
    logic [2*(DATA_WIDTH+1)-1:0]   in_data;
    logic signed [MEM_WIDTH-1:0]   threshold;
    logic                          frame_start;
    logic                          mem_clear;
    logic [1:0]                    spikes;
    logic                          spike_valid;
    logic [IDX_W-1:0]              neuron_idx;
    logic                          busy;
    logic                          drop;

    modport master (
        output in_valid, in_data, threshold, frame_start, mem_clear,
        input  spikes, spike_valid, neuron_idx, busy, drop
    );

    modport slave (
        input  in_valid, in_data, threshold, frame_start, mem_clear,
        output spikes, spike_valid, neuron_idx, busy, drop
    );
endinterface

// File: rtl/lif_update.sv
// Two-lane leaky integrate-and-fire membrane stage: shift leak, saturating integrate,
// threshold fire with reset-to-zero, plus a one-neuron-per-cycle clear sweep.
module lif_update #(
    parameter int DATA_WIDTH = 15,
    parameter int MEM_WIDTH  = 18,
    parameter int NEURONS    = 32,
    parameter int LEAK_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    lif_update_if.slave bus
);
    localparam int LANE_W = DATA_WIDTH + 1;
    localparam int SUM_W  = MEM_WIDTH + 1;
    localparam int IDX_W  = $clog2(NEURONS);

    localparam logic signed [SUM_W-1:0]     SUM_MAX = {2'b00, {(MEM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]     SUM_MIN = {2'b11, {(MEM_WIDTH-1){1'b0}}};
    localparam logic signed [MEM_WIDTH-1:0] MEM_MAX = {1'b0, {(MEM_WIDTH-1){1'b1}}};
    localparam logic signed [MEM_WIDTH-1:0] MEM_MIN = {1'b1, {(MEM_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            sweepAddr_q;
    logic                        busy_q;
    logic                        drop_q;
    logic [IDX_W-1:0]            count_q, count_d;
    logic                        s1Valid_q;
    logic signed [LANE_W-1:0]    s1Cur0_q, s1Cur1_q;
    logic [IDX_W-1:0]            s1Idx_q;
    logic [1:0]                  spikes_q;
    logic                        spikeValid_q;
    logic [IDX_W-1:0]            neuronIdx_q;
    logic signed [MEM_WIDTH-1:0] mem0_q [NEURONS];
    logic signed [MEM_WIDTH-1:0] mem1_q [NEURONS];

    logic                        accept;
    logic [IDX_W-1:0]            beatIdx;
    logic signed [LANE_W-1:0]    cur0, cur1;
    logic signed [MEM_WIDTH-1:0] v0, v1, sum0, sum1;
    logic                        fire0, fire1;
    logic                        writeEn;

    // The sum is one bit wider than the membrane so the leak/integrate result cannot wrap
    // before it is clamped back into the membrane range.
    function automatic logic signed [MEM_WIDTH-1:0] integrate(
        input logic signed [MEM_WIDTH-1:0] v,
        input logic signed [LANE_W-1:0]    cur
    );
        logic signed [MEM_WIDTH-1:0] leak;
        logic signed [SUM_W-1:0]     sum;
        leak = v >>> LEAK_SHIFT;
        sum  = {v[MEM_WIDTH-1], v} - {leak[MEM_WIDTH-1], leak}
             + {{(SUM_W-LANE_W){cur[LANE_W-1]}}, cur};
        if (sum > SUM_MAX)
            integrate = MEM_MAX;
        else if (sum < SUM_MIN)
            integrate = MEM_MIN;
        else
            integrate = sum[MEM_WIDTH-1:0];
    endfunction

    assign cur0 = bus.in_data[LANE_W-1:0];
    assign cur1 = bus.in_data[2*LANE_W-1:LANE_W];

    always_comb begin
        accept  = bus.in_valid && !busy_q;
        beatIdx = bus.frame_start ? '0 : count_q;
        count_d = count_q;
        if (accept)
            count_d = beatIdx + IDX_W'(1);
        else if (bus.frame_start)
            count_d = '0;
    end

    // Membranes are read in the compute cycle, so the previous beat's writeback is always visible.
    assign v0      = mem0_q[s1Idx_q];
    assign v1      = mem1_q[s1Idx_q];
    assign sum0    = integrate(v0, s1Cur0_q);
    assign sum1    = integrate(v1, s1Cur1_q);
    assign fire0   = sum0 >= $signed(bus.threshold);
    assign fire1   = sum1 >= $signed(bus.threshold);
    assign writeEn = s1Valid_q && !busy_q && !bus.mem_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sweepAddr_q  <= '0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            count_q      <= '0;
            s1Valid_q    <= 1'b0;
            s1Cur0_q     <= '0;
            s1Cur1_q     <= '0;
            s1Idx_q      <= '0;
            spikes_q     <= '0;
            spikeValid_q <= 1'b0;
            neuronIdx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_clear) begin
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        sweepAddr_q <= '0;
                    end
                end
                CLEAR: begin
                    sweepAddr_q <= sweepAddr_q + IDX_W'(1);
                    if (sweepAddr_q == IDX_W'(NEURONS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (bus.in_valid && busy_q)
                drop_q <= 1'b1;

            count_q   <= count_d;
            s1Valid_q <= accept;
            if (accept) begin
                s1Cur0_q <= cur0;
                s1Cur1_q <= cur1;
                s1Idx_q  <= beatIdx;
            end

            spikeValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                spikes_q    <= {fire1, fire0};
                neuronIdx_q <= s1Idx_q;
            end
        end
    end

    // Sweep writes win over an in-flight writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NEURONS; i++) begin
                mem0_q[i] <= '0;
                mem1_q[i] <= '0;
            end
        end else if (busy_q) begin
            mem0_q[sweepAddr_q] <= '0;
            mem1_q[sweepAddr_q] <= '0;
        end else if (writeEn) begin
            mem0_q[s1Idx_q] <= fire0 ? '0 : sum0;
            mem1_q[s1Idx_q] <= fire1 ? '0 : sum1;
        end
    end

    assign bus.spikes      = spikes_q;
    assign bus.spike_valid = spikeValid_q;
    assign bus.neuron_idx  = neuronIdx_q;
    assign bus.busy        = busy_q;
    assign bus.drop        = drop_q;
endmodule

// File: tb/tb_lif_update.sv
// Directed bench for lif_update with four neurons per lane; expected spikes are queued
// at issue time and matched by a monitor when spike_valid appears.
module tb_lif_update;
    localparam int DW = 15;
    localparam int MW = 18;
    localparam int NN = 4;
    localparam int IW = 2;
    localparam int LW = DW + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lif_update_if #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .NEURONS(NN)) bus();

    lif_update #(
        .DATA_WIDTH(DW),
        .MEM_WIDTH (MW),
        .NEURONS   (NN),
        .LEAK_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]    spk;
        logic [IW-1:0] idx;
        int            due;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleCnt   = 0;

    always @(posedge clk) cycleCnt++;

    // Every spike_valid pulse must match the oldest outstanding beat, including its latency.
    always @(negedge clk) begin
        if (bus.spike_valid === 1'b1) begin
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_spike_valid spikes=%b idx=%0d cycle=%0d required no output",
                         bus.spikes, bus.neuron_idx, cycleCnt);
            end else begin
                monExp = expQ.pop_front();
                if (bus.spikes === monExp.spk && bus.neuron_idx === monExp.idx && cycleCnt == monExp.due)
                    passCount++;
                else
                    $display("[TB] FAIL spike_out spikes=%b idx=%0d cycle=%0d required spikes=%b idx=%0d cycle=%0d",
                             bus.spikes, bus.neuron_idx, cycleCnt, monExp.spk, monExp.idx, monExp.due);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req)
            passCount++;
        else
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid    = 1'b0;
            bus.frame_start = 1'b0;
            bus.mem_clear   = 1'b0;
        end
    endtask

    task automatic setThreshold(input int t);
        idle(3);
        bus.threshold = MW'(t);
    endtask

    task automatic applyStimulus(input bit fs, input int c0, input int c1,
                                 input bit [1:0] spk, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b1;
        bus.frame_start = fs;
        bus.mem_clear   = 1'b0;
        bus.in_data     = {LW'(c1), LW'(c0)};
        e.spk = spk;
        e.idx = IW'(idx);
        e.due = cycleCnt + 2;
        expQ.push_back(e);
    endtask

    initial begin
        int waitCycles;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.threshold   = '0;
        bus.frame_start = 1'b0;
        bus.mem_clear   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_spike_valid", 32'(bus.spike_valid), 0);
        checkOutput("reset_spikes", 32'(bus.spikes), 0);
        checkOutput("reset_neuron_idx", 32'(bus.neuron_idx), 0);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_drop", 32'(bus.drop), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Integration with leak, streamed back to back: 64, then 64-4+64=124 fires at threshold 100.
        setThreshold(100);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NN; i++)
                applyStimulus(1'b0, (i == 0) ? 64 : 0, 0,
                              (f == 1 && i == 0) ? 2'b01 : 2'b00, i);

        // Negative saturation on lane 1 neuron 2: -32768, -63488, -92288, -119288, clamp -131072.
        setThreshold(131071);
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < NN; i++)
                applyStimulus(1'b0, 0, (i == 2) ? -32768 : 0, 2'b00, i);
        // Clamped membrane leaks to -122880: just below this threshold, zero-valued lanes fire.
        setThreshold(-122879);
        for (int i = 0; i < NN; i++)
            applyStimulus(1'b0, 0, 0, (i == 2) ? 2'b01 : 2'b11, i);
        // -122880 leaks to -115200, which now reaches the threshold.
        setThreshold(-115200);
        for (int i = 0; i < NN; i++)
            applyStimulus(1'b0, 0, 0, 2'b11, i);

        // Lane independence and frame_start: lane1 -5, then -5+1-5=-9, then -9+1=-8.
        setThreshold(150);
        applyStimulus(1'b0, 200, -5, 2'b01, 0);
        applyStimulus(1'b0, 200, -5, 2'b01, 1);
        applyStimulus(1'b1, 200, -5, 2'b01, 0);
        applyStimulus(1'b0, 200, -5, 2'b01, 1);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b1;
        applyStimulus(1'b0, 0, 0, 2'b00, 0);

        // Charge to ~50, then clear with the last charge beat still in flight.
        setThreshold(100);
        applyStimulus(1'b1, 50, 50, 2'b00, 0);
        for (int i = 1; i < NN; i++)
            applyStimulus(1'b0, 50, 50, 2'b00, i);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.mem_clear   = 1'b1;
        @(negedge clk);
        checkOutput("busy_before_sweep", 32'(bus.busy), 0);
        for (int i = 0; i < NN; i++) begin
            @(posedge clk);
            #1;
            bus.mem_clear = (i == 0);
            bus.in_valid  = (i == 2);
            bus.in_data   = {LW'(60), LW'(60)};
            @(negedge clk);
            checkOutput($sformatf("busy_sweep_%0d", i), 32'(bus.busy), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.mem_clear = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_sweep", 32'(bus.busy), 0);
        checkOutput("drop_after_sweep", 32'(bus.drop), 1);
        // Cleared membranes give 60 (< 100); uncleared ones would reach 107 and fire.
        for (int i = 0; i < NN; i++)
            applyStimulus(1'b0, 60, 60, 2'b00, i);
        idle(3);

        // Reset during a sweep with a beat in flight: nothing may emerge afterwards.
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {LW'(0), LW'(90)};
        bus.mem_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.mem_clear = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_spike_valid", 32'(bus.spike_valid), 0);
        checkOutput("rst_drop", 32'(bus.drop), 0);
        // v=0 gives 50 at index 0; a stale 60 at any index would give 107 and fire.
        applyStimulus(1'b0, 50, 0, 2'b00, 0);
        idle(2);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 50) begin
            @(posedge clk);
            waitCycles++;
        end
        idle(3);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/lif_update.md
Name: lif_update

Overview:
- Leaky integrate-and-fire membrane stage directly downstream of the convolution accumulator.
- Consumes each valid two-lane accumulated current beat and updates one membrane-potential pair (lane 0 / lane 1) selected by an internal neuron counter.
- Applies shift-based leak, saturating integration and threshold compare, then emits a spike pair with the neuron index.
- Membranes live in a local register array, cleared by reset or by a runtime clear sweep.

Parameters:
- DATA_WIDTH, 15, weight width of the conv stage; each input lane is DATA_WIDTH+1 bits signed.
- MEM_WIDTH, 18, signed membrane-potential width; must be ≥ DATA_WIDTH+2.
- NEURONS, 32, neurons per lane; power of two, ≥ 4.
- LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, current beat valid (driven by conv valid).
- in_data, input, 2*(DATA_WIDTH+1), packed signed currents: lane0 = [DATA_WIDTH:0], lane1 = upper half.
- threshold, input, MEM_WIDTH, signed firing threshold, shared by both lanes.
- frame_start, input, 1, forces neuron counter to 0.
- mem_clear, input, 1, pulse; starts clear sweep of all membranes.
- spikes, output, 2, spike per lane (bit0 = lane0).
- spike_valid, output, 1, spikes/neuron_idx valid.
- neuron_idx, output, $clog2(NEURONS), index of reported neuron.
- busy, output, 1, clear sweep in progress.
- drop, output, 1, sticky: a beat arrived while busy; cleared only by rst.

Behaviour:
- Reset: all outputs 0, counter 0, all membranes 0, FSM IDLE, pipeline empty.
- Counter n:
  - Each accepted in_valid uses the current n, then n increments, wrapping NEURONS-1 → 0.
  - frame_start with in_valid: beat uses index 0, n becomes 1.
  - frame_start alone: n = 0.
- Pipeline, 2 stages, fixed latency 2:
  - S1 (cycle of acceptance): register both lane currents and n; read membranes v0, v1 at n.
  - S2 (next cycle), per lane:
    - s = v - (v >>> LEAK_SHIFT) + sign_ext(current), computed at MEM_WIDTH+1 bits.
    - Clamp s to [-2^(MEM_WIDTH-1), 2^(MEM_WIDTH-1)-1].
    - If s ≥ threshold (signed, threshold sampled in S2): spike = 1, write back 0. Else spike = 0, write back s.
  - Outputs are registered: spikes, neuron_idx and spike_valid appear 2 cycles after in_valid, as a single-cycle spike_valid pulse per beat.
  - Back-to-back beats every cycle are supported. No read/write hazard, since consecutive beats use distinct indices (NEURONS ≥ 4).
- Leak on negative v: arithmetic shift floors, so v = -1 decays to 0. Membranes do not stick at -1.
- FSM:
  - IDLE → CLEAR on mem_clear (while IDLE).
  - CLEAR: a sweep address counts 0..NEURONS-1, one per cycle, writing 0 to both lanes. busy = 1 for exactly NEURONS cycles, starting the cycle after mem_clear.
  - CLEAR → IDLE after address NEURONS-1.
  - mem_clear during CLEAR is ignored.
- Beats while busy: not accepted, counter unchanged, no spike_valid, drop set.
- In-flight beat when clear starts:
  - The S2 result is still reported on spikes/spike_valid.
  - Its writeback is suppressed whenever busy = 1 or mem_clear = 1 in the S2 cycle; clear writes have priority.
- rst mid-sweep or mid-pipeline: everything returns to the reset state next cycle; the pipeline is flushed with no spike_valid.
- A threshold ≤ 0 is legal; a neuron then fires whenever s ≥ threshold, including on zero current.

Test Plan:
- Integration/leak: NEURONS=4, threshold=100, lane0 current 64 to neuron 0 in two frames (beats at idx 0..3, twice) → frame 1 spikes=00, v=64; frame 2 v=64-4+64=124 → spikes[0]=1 at neuron_idx=0, membrane written 0.
- Latency/streaming: 8 consecutive in_valid cycles → exactly 8 spike_valid pulses, each 2 cycles after its beat, neuron_idx 0,1,2,3,0,1,2,3.
- Negative saturation: threshold=131071, lane1 current -32768 to neuron 2 for 5 frames → membrane -32768, -63488, -92288, -119288, then clamped -131072; no spike.
- Lane independence / frame_start: lane0 +200, lane1 -5, threshold=150 → spikes=01. frame_start with in_valid after 2 beats → that beat reports neuron_idx=0.
- Clear sweep: charge all neurons to 50, pulse mem_clear, send in_valid during sweep → busy high exactly NEURONS cycles, drop=1, no spike_valid. After sweep, current 60 with threshold=100 → no spike (v=60, not 107).
- Reset mid-operation: assert rst during the sweep with beats in flight → next cycle busy=0, spike_valid=0, drop=0, counter 0. First subsequent beat reports neuron_idx=0 from v=0.
